grid_light_sequencer: RTL and testbench
=======================================

# grid_light_sequencer

Parametrised light-position sequencer for the whack-a-mole board. It accepts a linear mole index over a valid/ready handshake and decodes it to row/column by iterative subtraction. It then drives the selected light for a programmable number of cycles and reports whether the mole was hit or timed out. It sits between the random mole generator and the LED/grid driver, and supports any ROWS x COLS board.

## Interface
- ROWS, 3, number of grid rows (1..16)
- COLS, 3, number of grid columns (1..16)
- HOLD_W, 16, width of hold-time field
- IDX_W, $clog2(ROWS*COLS) (min 1), derived: index width
- ROW_W / COL_W, $clog2(ROWS) / $clog2(COLS) (min 1), derived
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  high iff state IDLE
- req_index  in  IDX_W  linear mole index, row-major (index = row*COLS + col)
- req_hold  in  HOLD_W  lit duration in cycles; 0 treated as 1
- hit  in  1  player strike on the lit position
- light_row  out  ROW_W  decoded row
- light_col  out  COL_W  decoded column
- coordinates  out  COL_W+ROW_W  {light_col, light_row}
- row_onehot  out  ROWS  one-hot row drive, gated by light_on
- col_onehot  out  COLS  one-hot column drive, gated by light_on
- light_on  out  1  selected light lit
- done  out  1  one-cycle pulse at end of a lit period
- done_hit  out  1  valid with done: 1 = ended by hit, 0 = timeout
- err  out  1  one-cycle pulse: out-of-range index rejected

## Operation
- States: IDLE, DECODE, LIT.
- IDLE:
  - On req_valid && req_ready, if req_index < ROWS*COLS: capture rem=req_index, row_cnt=0, hold_cnt=max(req_hold,1), then go to DECODE.
  - If req_index >= ROWS*COLS: pulse err next cycle and stay IDLE. Coordinates are unchanged and no light is lit.
- DECODE, one step per cycle:
  - If rem >= COLS: rem -= COLS, row_cnt += 1.
  - Else: light_row=row_cnt, light_col=rem[COL_W-1:0], go to LIT.
- LIT:
  - light_on=1.
  - Each cycle: if hit, exit with done_hit=1. Else if hold_cnt==1, exit with done_hit=0. Else hold_cnt -= 1.
  - Hit and expiry in the same cycle: hit wins.
- Exit returns to IDLE. done pulses in the first IDLE cycle, the same cycle light_on drops and req_ready rises.
- hit outside LIT is ignored.
- req_index and req_hold are sampled only at accept. Later changes have no effect.
- light_row/light_col/coordinates hold their last decoded value after done and are updated only on entering LIT.
- row_onehot/col_onehot are zero whenever light_on=0.

## Timing
- Reset values: req_ready=1 once resetn is high (state IDLE). Every other output is 0. State is IDLE.
- Latency for accept at cycle 0, index at row r:
  - DECODE occupies cycles 1..r+1.
  - light_on is high from cycle r+2.
  - Lit for exactly max(req_hold,1) cycles unless hit.
- hit sampled high in lit cycle k: light_on low at k+1, done=1, done_hit=1 at k+1.
- err is registered and pulses in cycle 1.
- Back-to-back: a new request may be accepted in the done cycle. Its light_on is high no earlier than r+2 cycles later.
- resetn low at any point, including mid-DECODE or mid-LIT: all outputs clear immediately (asynchronously). No done or err is emitted for the aborted request.
- Arithmetic is unsigned. rem and row_cnt are sized so the subtraction never wraps for index <= ROWS*COLS-1.

## Structure
- Package grid_light_pkg holds:
  - the state enum (IDLE, DECODE, LIT);
  - a width helper function clog2_min1.
- Sub-module grid_index_divider: the iterative subtract-by-COLS divider.
  - Ports: start, index → quotient (row), remainder (col), valid.
  - The top holds the FSM, hold counter and one-hot expansion.

## Test plan
- Default 3x3, index 7, hold 4, accept at cycle 0:
  - DECODE cycles 1–3.
  - light_on cycles 4–7 with row=2, col=1, coordinates=4'b0110, row_onehot=3'b100, col_onehot=3'b010.
  - done=1, done_hit=0 at cycle 8.
- Index 0, hold 10, hit in 3rd lit cycle: light_on for 3 cycles (2–4), done_hit=1 at cycle 5.
- Index 9 on 3x3: err pulse at cycle 1, req_ready stays 1, light_on stays 0, coordinates unchanged.
- req_hold=0, index 4: exactly one lit cycle (cycle 3), row=1, col=1, timeout done at cycle 4.
- resetn deasserted during LIT: light_on, one-hots and coordinates go to 0 immediately. After release, req_ready=1 and no done is emitted.
- ROWS=4, COLS=5, index 19, hold 2: 4 DECODE cycles, light row=3 col=4 on cycles 5–6, done at 7. A simultaneous hit and expiry on cycle 6 gives done_hit=1.

Source files
------------

// File: rtl/grid_light_pkg.sv
// Shared types and helpers for the grid light sequencer.
//   state_t    : sequencer FSM states
//   clog2_min1 : $clog2 clamped to a minimum of 1, so 1-wide grids still get a 1-bit field
package grid_light_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    LIT    = 2'd2
  } state_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/grid_index_divider.sv
// Iterative divide-by-COLS: one subtraction per cycle after start.
//   clk, resetn : clock, async active-low reset
//   start       : load index and begin (ignored while a divide is in flight only by caller contract)
//   index       : linear index to divide
//   quotient    : row count (registered)
//   remainder   : column (registered)
//   valid       : high during the cycle the remainder has dropped below COLS
module grid_index_divider #(
  parameter int unsigned COLS  = 3,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned ROW_W = 2,
  parameter int unsigned COL_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [IDX_W-1:0] index,
  output logic [ROW_W-1:0] quotient,
  output logic [COL_W-1:0] remainder,
  output logic             valid
);

  // One extra bit so COLS itself is representable even when IDX_W is tight.
  localparam int unsigned REM_W = IDX_W + 1;

  logic [REM_W-1:0] rem_q;
  logic [ROW_W-1:0] quo_q;
  logic             busy_q;
  logic             ge_cols;

  assign ge_cols   = (rem_q >= REM_W'(COLS));
  // Combinational so the caller can latch the result in the same cycle it settles.
  assign valid     = busy_q && !ge_cols;
  assign quotient  = quo_q;
  assign remainder = rem_q[COL_W-1:0];

  // Subtract-and-count datapath.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q  <= '0;
      quo_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= REM_W'(index);
      quo_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (ge_cols) begin
        rem_q <= rem_q - REM_W'(COLS);
        quo_q <= quo_q + ROW_W'(1);
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/grid_light_sequencer.sv
// Whack-a-mole light sequencer: accepts a linear index, decodes it to row/col,
// lights it for a programmable hold time and reports hit or timeout.
//   clk, resetn          : clock, async active-low reset
//   req_valid/req_ready  : request handshake (ready iff IDLE)
//   req_index, req_hold  : row-major index and lit duration (0 acts as 1)
//   hit                  : player strike, only honoured while lit
//   light_row/light_col  : last decoded position; coordinates = {col,row}
//   row_onehot/col_onehot: one-hot drives, zero while not lit
//   light_on             : selected light lit
//   done/done_hit        : end-of-lit pulse and its cause (1 = hit)
//   err                  : pulse for a rejected out-of-range index
module grid_light_sequencer
  import grid_light_pkg::*;
#(
  parameter  int unsigned ROWS   = 3,
  parameter  int unsigned COLS   = 3,
  parameter  int unsigned HOLD_W = 16,
  localparam int unsigned IDX_W  = clog2_min1(ROWS * COLS),
  localparam int unsigned ROW_W  = clog2_min1(ROWS),
  localparam int unsigned COL_W  = clog2_min1(COLS)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [IDX_W-1:0]       req_index,
  input  logic [HOLD_W-1:0]      req_hold,
  input  logic                   hit,
  output logic [ROW_W-1:0]       light_row,
  output logic [COL_W-1:0]       light_col,
  output logic [COL_W+ROW_W-1:0] coordinates,
  output logic [ROWS-1:0]        row_onehot,
  output logic [COLS-1:0]        col_onehot,
  output logic                   light_on,
  output logic                   done,
  output logic                   done_hit,
  output logic                   err
);

  localparam int unsigned CMP_W = IDX_W + 1;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [ROW_W-1:0]  row_d;
  logic [COL_W-1:0]  col_d;
  logic [ROWS-1:0]   row_oh_d;
  logic [COLS-1:0]   col_oh_d;
  logic              light_on_d, done_d, done_hit_d, err_d, ready_d;
  logic              div_start_c;
  logic [ROW_W-1:0]  div_quo;
  logic [COL_W-1:0]  div_rem;
  logic              div_valid;
  logic              in_range_c;

  grid_index_divider #(
    .COLS (COLS),
    .IDX_W(IDX_W),
    .ROW_W(ROW_W),
    .COL_W(COL_W)
  ) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (div_start_c),
    .index    (req_index),
    .quotient (div_quo),
    .remainder(div_rem),
    .valid    (div_valid)
  );

  assign in_range_c  = (CMP_W'(req_index) < CMP_W'(ROWS * COLS));
  assign coordinates = {light_col, light_row};

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    row_d       = light_row;
    col_d       = light_col;
    row_oh_d    = '0;
    col_oh_d    = '0;
    light_on_d  = 1'b0;
    done_d      = 1'b0;
    done_hit_d  = 1'b0;
    err_d       = 1'b0;
    div_start_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (in_range_c) begin
            div_start_c = 1'b1;
            hold_d      = (req_hold == '0) ? HOLD_W'(1) : req_hold;
            state_d     = DECODE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DECODE: begin
        if (div_valid) begin
          row_d      = div_quo;
          col_d      = div_rem;
          row_oh_d   = ROWS'(1) << div_quo;
          col_oh_d   = COLS'(1) << div_rem;
          light_on_d = 1'b1;
          state_d    = LIT;
        end
      end
      LIT: begin
        // Hit takes priority over expiry in the same cycle.
        if (hit || (hold_q == HOLD_W'(1))) begin
          done_d     = 1'b1;
          done_hit_d = hit;
          state_d    = IDLE;
        end else begin
          hold_d     = hold_q - HOLD_W'(1);
          row_oh_d   = row_onehot;
          col_oh_d   = col_onehot;
          light_on_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      light_row  <= '0;
      light_col  <= '0;
      row_onehot <= '0;
      col_onehot <= '0;
      light_on   <= 1'b0;
      done       <= 1'b0;
      done_hit   <= 1'b0;
      err        <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      light_row  <= row_d;
      light_col  <= col_d;
      row_onehot <= row_oh_d;
      col_onehot <= col_oh_d;
      light_on   <= light_on_d;
      done       <= done_d;
      done_hit   <= done_hit_d;
      err        <= err_d;
      req_ready  <= ready_d;
    end
  end

endmodule

// File: tb/tb_grid_light_sequencer.sv
// Self-checking bench for grid_light_sequencer on a 3x3 and a 4x5 board.
module tb_grid_light_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  req_index;
  logic [15:0] req_hold;
  logic        a_valid, a_hit, b_valid, b_hit;

  logic       a_ready, a_on, a_done, a_dh, a_err;
  logic [1:0] a_row, a_col;
  logic [3:0] a_crd;
  logic [2:0] a_roh, a_coh;

  logic       b_ready, b_on, b_done, b_dh, b_err;
  logic [1:0] b_row;
  logic [2:0] b_col;
  logic [4:0] b_crd;
  logic [3:0] b_roh;
  logic [4:0] b_coh;

  int checks = 0;
  int errors = 0;

  int o_rdy, o_on, o_done, o_dh, o_err, o_row, o_col, o_crd, o_roh, o_coh;
  int cur_row[2];
  int cur_col[2];
  int pend_done[2];
  int pend_hit[2];

  always #5 clk = ~clk;

  grid_light_sequencer dut_a (
    .clk(clk), .resetn(resetn), .req_valid(a_valid), .req_ready(a_ready),
    .req_index(req_index[3:0]), .req_hold(req_hold), .hit(a_hit),
    .light_row(a_row), .light_col(a_col), .coordinates(a_crd),
    .row_onehot(a_roh), .col_onehot(a_coh), .light_on(a_on),
    .done(a_done), .done_hit(a_dh), .err(a_err)
  );

  grid_light_sequencer #(.ROWS(4), .COLS(5)) dut_b (
    .clk(clk), .resetn(resetn), .req_valid(b_valid), .req_ready(b_ready),
    .req_index(req_index), .req_hold(req_hold), .hit(b_hit),
    .light_row(b_row), .light_col(b_col), .coordinates(b_crd),
    .row_onehot(b_roh), .col_onehot(b_coh), .light_on(b_on),
    .done(b_done), .done_hit(b_dh), .err(b_err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic sample(input int inst);
    if (inst == 0) begin
      o_rdy = int'(a_ready); o_on = int'(a_on); o_done = int'(a_done); o_dh = int'(a_dh);
      o_err = int'(a_err); o_row = int'(a_row); o_col = int'(a_col); o_crd = int'(a_crd);
      o_roh = int'(a_roh); o_coh = int'(a_coh);
    end else begin
      o_rdy = int'(b_ready); o_on = int'(b_on); o_done = int'(b_done); o_dh = int'(b_dh);
      o_err = int'(b_err); o_row = int'(b_row); o_col = int'(b_col); o_crd = int'(b_crd);
      o_roh = int'(b_roh); o_coh = int'(b_coh);
    end
  endtask

  task automatic drive(input int inst, input int valid, input int hitv);
    a_valid = (inst == 0) && (valid != 0);
    b_valid = (inst == 1) && (valid != 0);
    a_hit   = (inst == 0) && (hitv != 0);
    b_hit   = (inst == 1) && (hitv != 0);
  endtask

  // One cycle with no request; any pending done is expected here.
  task automatic idle_cycle(input int inst);
    drive(inst, 0, int'($urandom_range(0, 1)));
    req_index = 5'($urandom_range(0, 31));
    @(negedge clk);
    sample(inst);
    checks++; if (o_rdy !== 1) begin errors++; $display("FAIL idle_ready inst=%0d got %0d want 1", inst, o_rdy); end
    checks++; if (o_on !== 0) begin errors++; $display("FAIL idle_light_on inst=%0d got %0d want 0", inst, o_on); end
    checks++; if (o_done !== pend_done[inst]) begin errors++; $display("FAIL idle_done inst=%0d got %0d want %0d", inst, o_done, pend_done[inst]); end
    if (pend_done[inst] != 0) begin
      checks++; if (o_dh !== pend_hit[inst]) begin errors++; $display("FAIL idle_done_hit inst=%0d got %0d want %0d", inst, o_dh, pend_hit[inst]); end
    end
    checks++; if (o_err !== 0) begin errors++; $display("FAIL idle_err inst=%0d got %0d want 0", inst, o_err); end
    checks++; if (o_row !== cur_row[inst] || o_col !== cur_col[inst]) begin errors++; $display("FAIL idle_coords inst=%0d got r%0d c%0d want r%0d c%0d", inst, o_row, o_col, cur_row[inst], cur_col[inst]); end
    checks++; if (o_roh !== 0 || o_coh !== 0) begin errors++; $display("FAIL idle_onehot inst=%0d got %0h/%0h want 0/0", inst, o_roh, o_coh); end
    pend_done[inst] = 0;
    @(posedge clk); #1;
  endtask

  // One accepted request, checked cycle by cycle against the timing rules.
  // Returns at the start of the done cycle. hit_k: lit cycle (1-based) of the
  // strike, 0 = none. abort_at: cycle to pulse reset, -1 = none.
  task automatic run_req(input int inst, input int idx, input int hold, input int hit_k, input int abort_at);
    int cols, r, cc, hl, ls, len, dc, dh, hb, e_on, e_row, e_col;
    cols = (inst == 0) ? 3 : 5;
    r  = idx / cols;
    cc = idx % cols;
    hl = (hold == 0) ? 1 : hold;
    dh = (hit_k != 0 && hit_k <= hl) ? 1 : 0;
    ls = r + 2;
    len = dh ? hit_k : hl;
    dc = ls + len;
    for (int c = 0; c < dc; c++) begin
      req_index = (c == 0) ? 5'(idx) : 5'($urandom_range(0, 31));
      req_hold  = (c == 0) ? 16'(hold) : 16'($urandom_range(0, 65535));
      hb = (c >= ls) ? ((hit_k != 0 && c == ls + hit_k - 1) ? 1 : 0) : int'($urandom_range(0, 1));
      drive(inst, (c == 0) ? 1 : 0, hb);
      if (c == abort_at) begin
        resetn = 1'b0;
        #1;
        sample(inst);
        checks++; if (o_on !== 0 || o_roh !== 0 || o_coh !== 0) begin errors++; $display("FAIL abort_light inst=%0d got on%0d %0h/%0h want 0", inst, o_on, o_roh, o_coh); end
        checks++; if (o_crd !== 0 || o_done !== 0 || o_err !== 0) begin errors++; $display("FAIL abort_outputs inst=%0d got crd%0d done%0d err%0d want 0", inst, o_crd, o_done, o_err); end
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int i = 0; i < 2; i++) begin cur_row[i] = 0; cur_col[i] = 0; pend_done[i] = 0; pend_hit[i] = 0; end
        return;
      end
      @(negedge clk);
      sample(inst);
      e_on  = (c >= ls) ? 1 : 0;
      e_row = e_on ? r : cur_row[inst];
      e_col = e_on ? cc : cur_col[inst];
      checks++; if (o_rdy !== ((c == 0) ? 1 : 0)) begin errors++; $display("FAIL req_ready inst=%0d idx=%0d cyc=%0d got %0d want %0d", inst, idx, c, o_rdy, (c == 0) ? 1 : 0); end
      checks++; if (o_on !== e_on) begin errors++; $display("FAIL light_on inst=%0d idx=%0d cyc=%0d got %0d want %0d", inst, idx, c, o_on, e_on); end
      checks++; if (o_done !== ((c == 0) ? pend_done[inst] : 0)) begin errors++; $display("FAIL done inst=%0d idx=%0d cyc=%0d got %0d want %0d", inst, idx, c, o_done, (c == 0) ? pend_done[inst] : 0); end
      if (c == 0 && pend_done[inst] != 0) begin
        checks++; if (o_dh !== pend_hit[inst]) begin errors++; $display("FAIL b2b_done_hit inst=%0d got %0d want %0d", inst, o_dh, pend_hit[inst]); end
      end
      checks++; if (o_err !== 0) begin errors++; $display("FAIL err inst=%0d idx=%0d cyc=%0d got %0d want 0", inst, idx, c, o_err); end
      checks++; if (o_row !== e_row || o_col !== e_col) begin errors++; $display("FAIL coords inst=%0d idx=%0d cyc=%0d got r%0d c%0d want r%0d c%0d", inst, idx, c, o_row, o_col, e_row, e_col); end
      checks++; if (o_crd !== ((e_col << 2) | e_row)) begin errors++; $display("FAIL coordinates inst=%0d cyc=%0d got %0h want %0h", inst, c, o_crd, (e_col << 2) | e_row); end
      checks++; if (o_roh !== (e_on ? (1 << r) : 0) || o_coh !== (e_on ? (1 << cc) : 0)) begin errors++; $display("FAIL onehot inst=%0d cyc=%0d got %0h/%0h want %0h/%0h", inst, c, o_roh, o_coh, e_on ? (1 << r) : 0, e_on ? (1 << cc) : 0); end
      if (c == 0) pend_done[inst] = 0;
      @(posedge clk); #1;
    end
    cur_row[inst]   = r;
    cur_col[inst]   = cc;
    pend_done[inst] = 1;
    pend_hit[inst]  = dh;
  endtask

  // Out-of-range request: err one cycle later, nothing else moves.
  task automatic run_bad(input int inst, input int idx);
    req_index = 5'(idx);
    req_hold  = 16'($urandom_range(0, 65535));
    drive(inst, 1, 0);
    @(negedge clk);
    sample(inst);
    checks++; if (o_done !== pend_done[inst]) begin errors++; $display("FAIL bad_done inst=%0d got %0d want %0d", inst, o_done, pend_done[inst]); end
    pend_done[inst] = 0;
    @(posedge clk); #1;
    drive(inst, 0, 0);
    @(negedge clk);
    sample(inst);
    checks++; if (o_err !== 1) begin errors++; $display("FAIL err_pulse inst=%0d idx=%0d got %0d want 1", inst, idx, o_err); end
    checks++; if (o_rdy !== 1 || o_on !== 0) begin errors++; $display("FAIL err_state inst=%0d got rdy%0d on%0d want rdy1 on0", inst, o_rdy, o_on); end
    checks++; if (o_row !== cur_row[inst] || o_col !== cur_col[inst]) begin errors++; $display("FAIL err_coords inst=%0d got r%0d c%0d want r%0d c%0d", inst, o_row, o_col, cur_row[inst], cur_col[inst]); end
    @(posedge clk); #1;
    @(negedge clk);
    sample(inst);
    checks++; if (o_err !== 0) begin errors++; $display("FAIL err_width inst=%0d got %0d want 0", inst, o_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(0, 0, 0);
    req_index = '0;
    req_hold  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sample(0);
    checks++; if (o_on !== 0 || o_done !== 0 || o_err !== 0 || o_dh !== 0) begin errors++; $display("FAIL reset_flags got on%0d done%0d err%0d dh%0d want 0", o_on, o_done, o_err, o_dh); end
    checks++; if (o_crd !== 0 || o_roh !== 0 || o_coh !== 0) begin errors++; $display("FAIL reset_position got %0h %0h %0h want 0", o_crd, o_roh, o_coh); end
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin cur_row[i] = 0; cur_col[i] = 0; pend_done[i] = 0; pend_hit[i] = 0; end
    idle_cycle(0);
    idle_cycle(1);
  endtask

  task automatic test_timeout();
    run_req(0, 7, 4, 0, -1);
    idle_cycle(0);
  endtask

  task automatic test_hit();
    run_req(0, 0, 10, 3, -1);
    idle_cycle(0);
  endtask

  task automatic test_err();
    run_bad(0, 9);
    run_bad(0, 15);
    idle_cycle(0);
  endtask

  task automatic test_hold_zero();
    run_req(0, 4, 0, 0, -1);
    idle_cycle(0);
  endtask

  task automatic test_reset_mid_lit();
    run_req(0, 5, 8, 0, 5);
    idle_cycle(0);
    idle_cycle(0);
  endtask

  task automatic test_large_board();
    run_req(1, 19, 2, 2, -1);
    idle_cycle(1);
    run_bad(1, 20);
    run_req(1, 12, 3, 0, -1);
    idle_cycle(1);
  endtask

  task automatic test_back_to_back();
    run_req(0, 8, 2, 0, -1);
    run_req(0, 3, 1, 1, -1);
    run_req(0, 1, 3, 0, -1);
    idle_cycle(0);
  endtask

  task automatic test_random(input int inst, input int n);
    int idx, maxi;
    maxi = (inst == 0) ? 10 : 22;
    for (int k = 0; k < n; k++) begin
      idx = int'($urandom_range(0, maxi));
      if (idx >= ((inst == 0) ? 9 : 20)) run_bad(inst, idx);
      else run_req(inst, idx, int'($urandom_range(0, 6)), int'($urandom_range(0, 8)), -1);
      if ($urandom_range(0, 1) == 0) idle_cycle(inst);
    end
    idle_cycle(inst);
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_hit();
    test_err();
    test_hold_zero();
    test_reset_mid_lit();
    test_large_board();
    test_back_to_back();
    test_random(0, 40);
    test_random(1, 25);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
